// File: rtl/ahbl_sram_req_if.sv
// AHB-Lite slave to single-beat SRAM request bridge: write 1 wait state, read 2, error 2-cycle ERROR.
// BUSY holds the request in REQ and adds one wait state per cycle; HREADYOUT stays low until completion.
module ahbl_sram_req_if #(
   parameter int MEM_AWIDTH = 19,
   parameter int MEM_DEPTH  = 512
) (
   input  logic                  HCLK,
   input  logic                  aresetn,
   input  logic                  HSEL,
   input  logic                  HREADYIN,
   input  logic                  HWRITE,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic [31:0]           HADDR,
   input  logic [31:0]           HWDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
   output logic                  ahbsram_req,
   output logic                  ahbsram_write,
   output logic [2:0]            ahbsram_size,
   output logic [MEM_AWIDTH-1:0] ahbsram_addr,
   output logic [31:0]           ahbsram_wdata,
   input  logic                  sramahb_ack,
   input  logic [31:0]           sramahb_rdata,
   input  logic                  BUSY
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RDATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t      state;
   logic        xfer_vld;
   logic        addr_err;
   logic        hready_int;
   logic [31:0] word_idx;
   logic        unused_bits;

   assign xfer_vld    = HSEL & HTRANS[1] & HREADYIN;
   assign word_idx    = 32'(HADDR[MEM_AWIDTH-1:2]);
   assign unused_bits = ^{HADDR[31:MEM_AWIDTH], HTRANS[0]};

   always_comb begin
      addr_err = 1'b0;
      if (HSIZE > 3'b010)
         addr_err = 1'b1;
      else if (HSIZE == 3'b001 && HADDR[0])
         addr_err = 1'b1;
      else if (HSIZE == 3'b010 && HADDR[1:0] != 2'b00)
         addr_err = 1'b1;
      if (word_idx >= 32'(MEM_DEPTH))
         addr_err = 1'b1;
   end

   // A write ack doubles as the completion cycle, so it must open the bus combinationally.
   always_comb begin
      hready_int = 1'b1;
      case (state)
         ST_REQ, ST_ERR1: hready_int = 1'b0;
         ST_WAIT:         hready_int = sramahb_ack & ahbsram_write;
         default:         hready_int = 1'b1;
      endcase
   end

   always_ff @(posedge HCLK or negedge aresetn) begin
      if (!aresetn) begin
         state         <= ST_IDLE;
         ahbsram_write <= 1'b0;
         ahbsram_size  <= 3'b000;
         ahbsram_addr  <= '0;
      end else if (hready_int && xfer_vld) begin
         ahbsram_write <= HWRITE;
         ahbsram_size  <= HSIZE;
         ahbsram_addr  <= HADDR[MEM_AWIDTH-1:0];
         state         <= addr_err ? ST_ERR1 : ST_REQ;
      end else begin
         case (state)
            ST_REQ:  if (!BUSY) state <= ST_WAIT;
            ST_WAIT: if (sramahb_ack) state <= ahbsram_write ? ST_IDLE : ST_RDATA;
            ST_ERR1: state <= ST_ERR2;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign HREADYOUT     = hready_int;
   assign HRESP         = (state == ST_ERR1) || (state == ST_ERR2);
   assign HRDATA        = (state == ST_RDATA) ? sramahb_rdata : 32'h0;
   assign ahbsram_req   = (state == ST_REQ) & ~BUSY;
   assign ahbsram_wdata = HWDATA;

endmodule

// File: tb/tb_ahbl_sram_req_if.sv
// Directed bench for ahbl_sram_req_if: hand-driven controller, outputs sampled on the falling edge.
module tb_ahbl_sram_req_if;

   localparam int AW = 19;
   localparam int DEPTH = 512;

   logic          HCLK = 1'b0;
   logic          aresetn;
   logic          HSEL, HREADYIN, HWRITE;
   logic [1:0]    HTRANS;
   logic [2:0]    HSIZE;
   logic [31:0]   HADDR, HWDATA;
   logic          HREADYOUT, HRESP;
   logic [31:0]   HRDATA;
   logic          ahbsram_req, ahbsram_write;
   logic [2:0]    ahbsram_size;
   logic [AW-1:0] ahbsram_addr;
   logic [31:0]   ahbsram_wdata;
   logic          sramahb_ack;
   logic [31:0]   sramahb_rdata;
   logic          BUSY;

   int checks = 0;
   int errors = 0;

   ahbl_sram_req_if #(.MEM_AWIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
      .HCLK(HCLK), .aresetn(aresetn),
      .HSEL(HSEL), .HREADYIN(HREADYIN), .HWRITE(HWRITE), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .ahbsram_req(ahbsram_req), .ahbsram_write(ahbsram_write),
      .ahbsram_size(ahbsram_size), .ahbsram_addr(ahbsram_addr),
      .ahbsram_wdata(ahbsram_wdata), .sramahb_ack(sramahb_ack),
      .sramahb_rdata(sramahb_rdata), .BUSY(BUSY)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge HCLK);
      #1;
   endtask

   task automatic sample();
      @(negedge HCLK);
   endtask

   task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [31:0] a);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HSIZE = sz; HADDR = a;
   endtask

   task automatic bus_idle();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b000; HADDR = 32'h0;
   endtask

   initial begin
      logic [2:0]  esz [3];
      logic [31:0] ead [3];
      esz[0] = 3'b011; ead[0] = 32'h0;
      esz[1] = 3'b001; ead[1] = 32'h1;
      esz[2] = 3'b001; ead[2] = DEPTH * 4;

      aresetn = 1'b0; HREADYIN = 1'b1; bus_idle(); HWDATA = 32'h0;
      sramahb_ack = 1'b0; sramahb_rdata = 32'hA5A5A5A5; BUSY = 1'b0;
      #2;
      chk("rst_hready", HREADYOUT, 1); chk("rst_hresp", HRESP, 0);
      chk("rst_hrdata", HRDATA, 0);    chk("rst_req", ahbsram_req, 0);
      chk("rst_write", ahbsram_write, 0); chk("rst_size", ahbsram_size, 0);
      chk("rst_addr", ahbsram_addr, 0);
      #20 aresetn = 1'b1;

      // word write 0x10
      next_cycle(); addr_phase(1, 3'b010, 32'h10); sample();
      chk("wr_a_hready", HREADYOUT, 1);
      next_cycle(); bus_idle(); HWDATA = 32'hDEADBEEF; sample();
      chk("wr_a1_req", ahbsram_req, 1); chk("wr_a1_addr", ahbsram_addr, 32'h10);
      chk("wr_a1_size", ahbsram_size, 3'b010); chk("wr_a1_write", ahbsram_write, 1);
      chk("wr_a1_wdata", ahbsram_wdata, 32'hDEADBEEF); chk("wr_a1_hready", HREADYOUT, 0);
      next_cycle(); sramahb_ack = 1'b1; sample();
      chk("wr_a2_hready", HREADYOUT, 1); chk("wr_a2_hresp", HRESP, 0);
      chk("wr_a2_req", ahbsram_req, 0);
      next_cycle(); sramahb_ack = 1'b0; sample();
      chk("wr_a3_hready", HREADYOUT, 1); chk("wr_a3_addr_hold", ahbsram_addr, 32'h10);

      // non-selected NONSEQ, then selected BUSY transfer type
      next_cycle(); HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010; HADDR = 32'h40; sample();
      next_cycle(); HSEL = 1'b1; HTRANS = 2'b01; sample();
      chk("nosel_req", ahbsram_req, 0); chk("nosel_hready", HREADYOUT, 1);
      next_cycle(); bus_idle(); sample();
      chk("htbusy_req", ahbsram_req, 0); chk("htbusy_hready", HREADYOUT, 1);
      chk("htbusy_addr_hold", ahbsram_addr, 32'h10);

      // word read 0x10
      next_cycle(); addr_phase(0, 3'b010, 32'h10); sample();
      next_cycle(); bus_idle(); sample();
      chk("rd_a1_hready", HREADYOUT, 0); chk("rd_a1_req", ahbsram_req, 1);
      chk("rd_a1_write", ahbsram_write, 0);
      next_cycle(); sramahb_ack = 1'b1; sramahb_rdata = 32'h12345678; sample();
      chk("rd_a2_hready", HREADYOUT, 0); chk("rd_a2_hrdata", HRDATA, 0);
      next_cycle(); sramahb_ack = 1'b0; sramahb_rdata = 32'hDEADBEEF; sample();
      chk("rd_a3_hready", HREADYOUT, 1); chk("rd_a3_hrdata", HRDATA, 32'hDEADBEEF);
      next_cycle(); sramahb_rdata = 32'h55AA55AA; sample();
      chk("rd_a4_hrdata", HRDATA, 0);

      // write with BUSY for three cycles, stray ack while in REQ
      next_cycle(); addr_phase(1, 3'b010, 32'h20); sample();
      next_cycle(); bus_idle(); HWDATA = 32'hCAFEF00D; BUSY = 1'b1; sample();
      chk("busy1_req", ahbsram_req, 0); chk("busy1_hready", HREADYOUT, 0);
      next_cycle(); sample();
      chk("busy2_req", ahbsram_req, 0);
      next_cycle(); sramahb_ack = 1'b1; sample();
      chk("busy3_req", ahbsram_req, 0); chk("busy3_stray_ack_hready", HREADYOUT, 0);
      next_cycle(); sramahb_ack = 1'b0; BUSY = 1'b0; sample();
      chk("busy_a4_req", ahbsram_req, 1); chk("busy_a4_hready", HREADYOUT, 0);
      next_cycle(); sramahb_ack = 1'b1; sample();
      chk("busy_a5_hready", HREADYOUT, 1); chk("busy_a5_req", ahbsram_req, 0);
      next_cycle(); sramahb_ack = 1'b0; sample();

      // error transfers: oversize, misaligned halfword, out-of-range halfword
      for (int i = 0; i < 3; i++) begin
         next_cycle(); addr_phase(1, esz[i], ead[i]); sample();
         next_cycle(); bus_idle(); sample();
         chk($sformatf("err%0d_a1_req", i), ahbsram_req, 0);
         chk($sformatf("err%0d_a1_hresp", i), HRESP, 1);
         chk($sformatf("err%0d_a1_hready", i), HREADYOUT, 0);
         next_cycle(); sample();
         chk($sformatf("err%0d_a2_req", i), ahbsram_req, 0);
         chk($sformatf("err%0d_a2_hresp", i), HRESP, 1);
         chk($sformatf("err%0d_a2_hready", i), HREADYOUT, 1);
         next_cycle(); sample();
         chk($sformatf("err%0d_a3_hresp", i), HRESP, 0);
      end

      // last in-range word is accepted
      next_cycle(); addr_phase(1, 3'b010, DEPTH * 4 - 4); sample();
      next_cycle(); bus_idle(); sample();
      chk("top_word_req", ahbsram_req, 1); chk("top_word_hresp", HRESP, 0);
      chk("top_word_addr", ahbsram_addr, DEPTH * 4 - 4);
      next_cycle(); sramahb_ack = 1'b1; sample();
      chk("top_word_done", HREADYOUT, 1);
      next_cycle(); sramahb_ack = 1'b0; sample();

      // back-to-back write 0x04 then read 0x08
      next_cycle(); addr_phase(1, 3'b010, 32'h04); sample();
      next_cycle(); bus_idle(); HWDATA = 32'h01020304; sample();
      chk("b2b_a1_req", ahbsram_req, 1); chk("b2b_a1_addr", ahbsram_addr, 32'h04);
      next_cycle(); sramahb_ack = 1'b1; addr_phase(0, 3'b010, 32'h08); sample();
      chk("b2b_a2_hready", HREADYOUT, 1);
      next_cycle(); sramahb_ack = 1'b0; bus_idle(); sample();
      chk("b2b_a3_req", ahbsram_req, 1); chk("b2b_a3_addr", ahbsram_addr, 32'h08);
      chk("b2b_a3_write", ahbsram_write, 0); chk("b2b_a3_hready", HREADYOUT, 0);
      next_cycle(); sramahb_ack = 1'b1; sample();
      chk("b2b_a4_hready", HREADYOUT, 0);
      next_cycle(); sramahb_ack = 1'b0; sramahb_rdata = 32'h0BADF00D; sample();
      chk("b2b_a5_hready", HREADYOUT, 1); chk("b2b_a5_hrdata", HRDATA, 32'h0BADF00D);

      // reset asserted while a read sits in WAIT
      next_cycle(); addr_phase(0, 3'b010, 32'h0C); sample();
      next_cycle(); bus_idle(); sample();
      chk("rstw_a1_req", ahbsram_req, 1);
      next_cycle(); sample();
      chk("rstw_a2_hready", HREADYOUT, 0);
      #1 aresetn = 1'b0;
      #1;
      chk("rstw_hready", HREADYOUT, 1); chk("rstw_req", ahbsram_req, 0);
      chk("rstw_addr", ahbsram_addr, 0); chk("rstw_write", ahbsram_write, 0);
      chk("rstw_size", ahbsram_size, 0); chk("rstw_hrdata", HRDATA, 0);
      @(negedge HCLK); aresetn = 1'b1;
      next_cycle(); addr_phase(0, 3'b010, 32'h14); sample();
      next_cycle(); bus_idle(); sample();
      chk("post_rst_req", ahbsram_req, 1); chk("post_rst_addr", ahbsram_addr, 32'h14);
      next_cycle(); sramahb_ack = 1'b1; sample();
      next_cycle(); sramahb_ack = 1'b0; sramahb_rdata = 32'h600DCAFE; sample();
      chk("post_rst_hready", HREADYOUT, 1); chk("post_rst_hrdata", HRDATA, 32'h600DCAFE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahbl_sram_req_if.md
# ahbl_sram_req_if

AHB-Lite slave front-end that converts AHB-Lite transfers into single-beat requests on the SRAM control request interface (ahbsram_req/ack) and returns completion, read data and error responses to the bus. It sits between the AHB-Lite interconnect and the SRAM control interface block, acting as the initiator on the request/ack side. It holds address, size and direction stable for the whole transaction, respects BUSY, and inserts HREADYOUT wait states.

## Interface
- MEM_AWIDTH, 19: byte-address width presented on ahbsram_addr.
- MEM_DEPTH, 512: memory depth in 32-bit words; word index >= MEM_DEPTH is out of range.
- HCLK  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- HSEL, HREADYIN, HWRITE  in  1 each  AHB-Lite select, bus-ready, direction.
- HTRANS  in  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) are acted on.
- HSIZE  in  3  transfer size.
- HADDR  in  32  byte address.
- HWDATA  in  32  write data (data phase).
- HREADYOUT  out  1  transfer complete / ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data.
- ahbsram_req  out  1  request strobe to SRAM controller.
- ahbsram_write  out  1  1=write, 0=read.
- ahbsram_size  out  3  registered HSIZE.
- ahbsram_addr  out  MEM_AWIDTH  registered HADDR[MEM_AWIDTH-1:0].
- ahbsram_wdata  out  32  write data to controller.
- sramahb_ack  in  1  single-cycle completion from controller.
- sramahb_rdata  in  32  read data, valid the cycle after ack.
- BUSY  in  1  memory busy; request must not be issued while high.

## Operation
- Valid transfer = HSEL & HTRANS[1] & HREADYIN, sampled at a rising edge when HREADYOUT=1.
- On valid transfer: register HWRITE, HSIZE, HADDR[MEM_AWIDTH-1:0]; decode error.
- Error if: HSIZE > 3'b010; HSIZE=001 with HADDR[0]=1; HSIZE=010 with HADDR[1:0]!=0; HADDR[MEM_AWIDTH-1:2] >= MEM_DEPTH. Error transfers issue no request.
- States: IDLE, REQ, WAIT, RDATA, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0. Valid OK transfer -> REQ; valid error transfer -> ERR1; else stay.
- REQ: HREADYOUT=0. ahbsram_req = ~BUSY. If BUSY, stay in REQ; else -> WAIT.
- WAIT: HREADYOUT = sramahb_ack & ahbsram_write. On ack: write -> completion cycle (new-transfer decode as IDLE); read -> RDATA. No ack: stay.
- RDATA: HREADYOUT=1, HRDATA=sramahb_rdata; new-transfer decode as IDLE.
- ERR1: HREADYOUT=0, HRESP=1 -> ERR2. ERR2: HREADYOUT=1, HRESP=1; new-transfer decode as IDLE.
- HRDATA = 0 outside RDATA. ahbsram_wdata = HWDATA (combinational; HWDATA is held stable while HREADYOUT=0).
- ahbsram_write/size/addr hold registered values from capture until the next valid transfer.
- Non-selected, IDLE or BUSY HTRANS: zero-wait OKAY, no request.

## Timing
- Reset (async): state IDLE; HREADYOUT=1, HRESP=0, HRDATA=0, ahbsram_req=0, ahbsram_write=0, ahbsram_size=0, ahbsram_addr=0. Reset mid-transaction aborts it; req drops immediately.
- Address phase at cycle A. Write: REQ in A+1 (req=1), ack in A+2, HREADYOUT=1 in A+2 (1 wait state).
- Read: REQ in A+1, ack in A+2, RDATA in A+3 with HREADYOUT=1 (2 wait states).
- ahbsram_req is high for exactly one cycle per transfer; each BUSY cycle in REQ adds one wait state.
- Error: ERR1 in A+1, ERR2 in A+2 (two-cycle ERROR).
- Back-to-back: an address phase in a completion cycle enters REQ/ERR1 next cycle with no IDLE gap.
- Ack outside WAIT is ignored.

## Test plan
- Word write HADDR=0x10, HWDATA=0xDEADBEEF, controller acks 1 cycle after req -> req high 1 cycle in A+1 with addr=0x10, size=010, write=1, wdata=0xDEADBEEF; HREADYOUT 0 then 1 in A+2; HRESP=0.
- Word read HADDR=0x10, sramahb_rdata=0xDEADBEEF cycle after ack -> HREADYOUT low A+1, A+2, high A+3 with HRDATA=0xDEADBEEF.
- BUSY high for 3 cycles at REQ -> req withheld 3 cycles, then one req pulse; write completes in A+5.
- HSIZE=011 and halfword at HADDR=0x1 and HADDR=MEM_DEPTH*4 -> no req; HRESP=1 in A+1 (HREADYOUT=0) and A+2 (HREADYOUT=1).
- Back-to-back write 0x04 then read 0x08 (second address phase in write completion cycle) -> second req in A+3, read data A+5, no idle gap.
- aresetn low during WAIT of a read -> outputs return to reset values immediately; after release, a new read completes normally.
